// File: rtl/sw_debounce_pkg.sv
// Shared defaults and sizing helpers for the switch debouncer.
// Imported by the interface, the per-bit debouncer and the top level.
package sw_debounce_pkg;

  localparam int unsigned WIDTH_DEF           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

  // Counter only needs to hold 0..DEBOUNCE_CYCLES-1; acceptance clears it before it could wrap.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle between the board-facing source and the debouncer.
// master drives the raw levels; slave returns the debounced levels and edge pulses.
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// Debouncer for one switch: two-flop synchroniser, stability counter,
// accepted level and registered stable/rise/fall outputs.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall,
  output logic chg_nxt
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt_p1;
  logic             lvl_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt_p1    <= '0;
      lvl_p1    <= 1'b0;
      sw_stable <= 1'b0;
      sw_rise   <= 1'b0;
      sw_fall   <= 1'b0;
    end else begin
      // stage 0: bring the asynchronous switch level into the clock domain
      sync1 <= sw_raw;
      sync2 <= sync1;

      // stage 1: a level is accepted only after it differs for DEBOUNCE_CYCLES cycles
      if (sync2 == lvl_p1) begin
        cnt_p1 <= '0;
      end else if (cnt_p1 == CNT_LAST) begin
        cnt_p1 <= '0;
        lvl_p1 <= sync2;
      end else begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end

      // stage 2: registered outputs; pulses mark the cycle sw_stable changes
      sw_stable <= lvl_p1;
      sw_rise   <= lvl_p1 & ~sw_stable;
      sw_fall   <= ~lvl_p1 & sw_stable;
    end
  end

  // Lets the top register sw_changed in the same cycle as rise/fall.
  assign chg_nxt = lvl_p1 ^ sw_stable;

endmodule

// File: rtl/sw_debounce.sv
// Multi-switch debouncer: one sw_debounce_bit per switch plus a registered
// sw_changed strobe that fires once when any bit accepts a new level.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = WIDTH_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  bus
);

  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] chg_nxt;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .sw_raw    (bus.sw_raw[i]),
      .sw_stable (stable_q[i]),
      .sw_rise   (rise_q[i]),
      .sw_fall   (fall_q[i]),
      .chg_nxt   (chg_nxt[i])
    );
  end

  // stage 2: aligned with the per-bit rise/fall registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |chg_nxt;
    end
  end

  assign bus.sw_stable  = stable_q;
  assign bus.sw_rise    = rise_q;
  assign bus.sw_fall    = fall_q;
  assign bus.sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=4, DEBOUNCE_CYCLES=4.
// Edge 0 is the first rising edge that samples a newly driven sw_raw value.
module tb_sw_debounce;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sw_debounce_if #(.WIDTH(4)) bus ();

  sw_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.sw_raw = 4'b0000;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sw_stable !== 4'b0000 || bus.sw_rise !== 4'b0000 ||
        bus.sw_fall !== 4'b0000 || bus.sw_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_async stable=%b rise=%b fall=%b chg=%b required all 0",
               bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed);
    end
    step();
    step();
    checks++;
    if (bus.sw_stable !== 4'b0000 || bus.sw_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_held stable=%b chg=%b required 0000/0", bus.sw_stable, bus.sw_changed);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_rise();
    bus.sw_raw = 4'b0001;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (bus.sw_stable !== ((e >= 6) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL single_stable edge=%0d got %b required %b", e, bus.sw_stable,
                 (e >= 6) ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (bus.sw_rise !== ((e == 6) ? 4'b0001 : 4'b0000) || bus.sw_fall !== 4'b0000) begin
        errors++;
        $display("FAIL single_pulse edge=%0d rise=%b fall=%b", e, bus.sw_rise, bus.sw_fall);
      end
      checks++;
      if (bus.sw_changed !== (e == 6)) begin
        errors++;
        $display("FAIL single_changed edge=%0d got %b required %b", e, bus.sw_changed, (e == 6));
      end
    end
  endtask

  task automatic test_glitch();
    bus.sw_raw = 4'b0000;
    for (int e = 0; e < 13; e++) begin
      if (e == 3) bus.sw_raw = 4'b0001;
      step();
      checks++;
      if (bus.sw_stable !== 4'b0001 || bus.sw_rise !== 4'b0000 ||
          bus.sw_fall !== 4'b0000 || bus.sw_changed !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge=%0d stable=%b rise=%b fall=%b chg=%b required 0001/0/0/0",
                 e, bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed);
      end
    end
  endtask

  task automatic test_multi_rise();
    bus.sw_raw = 4'b0000;
    for (int e = 0; e < 12; e++) step();
    checks++;
    if (bus.sw_stable !== 4'b0000) begin
      errors++;
      $display("FAIL multi_setup got %b required 0000", bus.sw_stable);
    end
    bus.sw_raw = 4'b1010;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (bus.sw_stable !== ((e >= 6) ? 4'b1010 : 4'b0000)) begin
        errors++;
        $display("FAIL multi_stable edge=%0d got %b required %b", e, bus.sw_stable,
                 (e >= 6) ? 4'b1010 : 4'b0000);
      end
      checks++;
      if (bus.sw_rise !== ((e == 6) ? 4'b1010 : 4'b0000) || bus.sw_fall !== 4'b0000 ||
          bus.sw_changed !== (e == 6)) begin
        errors++;
        $display("FAIL multi_pulse edge=%0d rise=%b fall=%b chg=%b", e, bus.sw_rise,
                 bus.sw_fall, bus.sw_changed);
      end
    end
  endtask

  task automatic test_all_fall();
    bus.sw_raw = 4'b1111;
    for (int e = 0; e < 12; e++) step();
    checks++;
    if (bus.sw_stable !== 4'b1111) begin
      errors++;
      $display("FAIL fall_setup got %b required 1111", bus.sw_stable);
    end
    bus.sw_raw = 4'b0000;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (bus.sw_stable !== ((e >= 6) ? 4'b0000 : 4'b1111)) begin
        errors++;
        $display("FAIL fall_stable edge=%0d got %b required %b", e, bus.sw_stable,
                 (e >= 6) ? 4'b0000 : 4'b1111);
      end
      checks++;
      if (bus.sw_fall !== ((e == 6) ? 4'b1111 : 4'b0000) || bus.sw_rise !== 4'b0000 ||
          bus.sw_changed !== (e == 6)) begin
        errors++;
        $display("FAIL fall_pulse edge=%0d fall=%b rise=%b chg=%b", e, bus.sw_fall,
                 bus.sw_rise, bus.sw_changed);
      end
    end
  endtask

  task automatic test_reset_midcount();
    bus.sw_raw = 4'b0001;
    for (int e = 0; e < 12; e++) step();
    bus.sw_raw = 4'b0100;
    for (int e = 0; e < 3; e++) step();
    checks++;
    if (bus.sw_stable !== 4'b0001) begin
      errors++;
      $display("FAIL midcount_pre got %b required 0001", bus.sw_stable);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sw_stable !== 4'b0000 || bus.sw_rise !== 4'b0000 ||
        bus.sw_fall !== 4'b0000 || bus.sw_changed !== 1'b0) begin
      errors++;
      $display("FAIL midcount_async stable=%b rise=%b fall=%b chg=%b required all 0",
               bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed);
    end
    step();
    step();
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (bus.sw_stable !== ((e >= 6) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL midcount_stable edge=%0d got %b required %b", e, bus.sw_stable,
                 (e >= 6) ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (bus.sw_rise !== ((e == 6) ? 4'b0100 : 4'b0000) || bus.sw_fall !== 4'b0000 ||
          bus.sw_changed !== (e == 6)) begin
        errors++;
        $display("FAIL midcount_pulse edge=%0d rise=%b fall=%b chg=%b", e, bus.sw_rise,
                 bus.sw_fall, bus.sw_changed);
      end
    end
  endtask

  task automatic test_high_through_reset();
    bus.sw_raw = 4'b1000;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.sw_stable !== 4'b0000 || bus.sw_changed !== 1'b0) begin
      errors++;
      $display("FAIL held_async stable=%b chg=%b required 0000/0", bus.sw_stable, bus.sw_changed);
    end
    step();
    step();
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      checks++;
      if (bus.sw_stable !== ((e >= 6) ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL held_stable edge=%0d got %b required %b", e, bus.sw_stable,
                 (e >= 6) ? 4'b1000 : 4'b0000);
      end
      checks++;
      if (bus.sw_rise !== ((e == 6) ? 4'b1000 : 4'b0000) || bus.sw_fall !== 4'b0000 ||
          bus.sw_changed !== (e == 6)) begin
        errors++;
        $display("FAIL held_pulse edge=%0d rise=%b fall=%b chg=%b", e, bus.sw_rise,
                 bus.sw_fall, bus.sw_changed);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_rise();
    test_glitch();
    test_multi_rise();
    test_all_fall();
    test_reset_midcount();
    test_high_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 4, number of independent switch inputs debounced.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), consecutive stable cycles required to accept a new level; legal range 2..2^24.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port sw_raw  input  WIDTH  unsynchronised board switch levels; bit i is switch i.
REQ-006 Port sw_stable  output  WIDTH  debounced switch levels, fed to the switch-to-LED logic.
REQ-007 Port sw_rise  output  WIDTH  one-cycle pulse per bit when sw_stable bit goes 0->1.
REQ-008 Port sw_fall  output  WIDTH  one-cycle pulse per bit when sw_stable bit goes 1->0.
REQ-009 Port sw_changed  output  1  one-cycle pulse, OR of all sw_rise and sw_fall bits in the same cycle.

Function
REQ-010 Each sw_raw bit SHALL pass through a two-flop synchroniser (sync1 -> sync2) before any other use; no combinational path from sw_raw to any output.
REQ-011 Each bit SHALL own a counter of width clog2(DEBOUNCE_CYCLES); counter clears whenever sync2 equals sw_stable for that bit.
REQ-012 While sync2 differs from sw_stable, the counter SHALL increment by 1 per cycle.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, on the next edge sw_stable SHALL take sync2, the counter SHALL clear, and the matching sw_rise or sw_fall bit SHALL be 1 for exactly that one cycle.
REQ-014 Latency: a clean level change on sw_raw held indefinitely SHALL appear on sw_stable exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-015 Glitch rule: any sync2 excursion shorter than DEBOUNCE_CYCLES cycles SHALL leave sw_stable unchanged and produce no pulses; counter returns to 0 when sync2 matches again.
REQ-016 Counter SHALL never wrap; it cannot exceed DEBOUNCE_CYCLES-1 because acceptance clears it.
REQ-017 Bits are fully independent; simultaneous acceptance on several bits SHALL pulse each corresponding rise/fall bit in the same cycle and sw_changed once.
REQ-018 sw_rise and sw_fall for the same bit SHALL never be 1 in the same cycle.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 Asserting rst SHALL immediately clear sync1, sync2, all counters, sw_stable, sw_rise, sw_fall and sw_changed to 0, regardless of clock.
REQ-021 Reset mid-count SHALL discard partial debounce progress; no pulse is generated by the reset itself.
REQ-022 A switch already high when rst deasserts SHALL be accepted normally: sw_stable bit rises DEBOUNCE_CYCLES+2 edges after release, with a sw_rise pulse.

Structure
REQ-023 A shared package/header SHALL hold the default WIDTH, the default DEBOUNCE_CYCLES and a clog2-based counter-width constant.
REQ-024 A per-bit sub-module sw_debounce_bit (synchroniser, counter, stable flop, rise/fall pulse) SHALL be instantiated WIDTH times by a generate loop; sw_changed is formed in the top level.

Verification (bench uses DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-025 Reset with sw_raw=4'b0000, then sw_raw=4'b0001 before edge 0 -> sw_stable=4'b0001 after edge 6; sw_rise=4'b0001 and sw_changed=1 for that cycle only.
REQ-026 From stable 4'b0001, sw_raw[0]=0 for 3 cycles then back to 1 -> sw_stable stays 4'b0001, no pulses at any time.
REQ-027 From stable 4'b0000, sw_raw 4'b0000->4'b1010 on one edge -> sw_stable=4'b1010 after 6 edges, sw_rise=4'b1010 in one cycle, sw_changed one pulse.
REQ-028 From stable 4'b1111, sw_raw=4'b0000 held -> sw_fall=4'b1111 single cycle, sw_stable=4'b0000, sw_rise never asserted.
REQ-029 sw_raw[2]=1 held, rst asserted 3 edges after change (mid-count) for 2 cycles -> outputs 0 asynchronously; after release sw_stable[2]=1 exactly 6 edges later with one sw_rise[2] pulse.
REQ-030 sw_raw=4'b1000 held through reset -> after deassertion sw_stable=4'b1000 at edge 6, single sw_rise[3] pulse.
